// File: rtl/atree_pipe_if.sv
// Beat/result bundle for atree_pipe: operand beats flow in, tree sums and frame totals flow out.
// The master drives beats; the slave (the tree) drives results.
interface atree_pipe_if #(
  parameter int IN_WIDTH  = 8,
  parameter int LEVELS    = 4,
  parameter int ACC_WIDTH = IN_WIDTH + LEVELS + 8
);
  logic                                 in_valid;
  logic                                 in_last;
  logic [(1<<LEVELS)-1:0][IN_WIDTH-1:0] inputs;
  logic                                 out_valid;
  logic [IN_WIDTH+LEVELS-1:0]           out;
  logic                                 acc_valid;
  logic [ACC_WIDTH-1:0]                 acc;
  logic                                 acc_ovf;

  modport master (
    output in_valid, in_last, inputs,
    input  out_valid, out, acc_valid, acc, acc_ovf
  );

  modport slave (
    input  in_valid, in_last, inputs,
    output out_valid, out, acc_valid, acc, acc_ovf
  );
endinterface

// File: rtl/atree_pipe.sv
// Pipelined adder tree: one register stage per level, valid/last sideband shifted alongside,
// and a frame accumulator that reports the running total on each last-tagged beat.
module atree_pipe #(
  parameter int IN_WIDTH  = 8,
  parameter int LEVELS    = 4,
  parameter int SIGNED    = 0,
  parameter int ACC_WIDTH = IN_WIDTH + LEVELS + 8
) (
  input logic        clk,
  input logic        rst,
  atree_pipe_if.slave bus
);
  localparam int N  = 1 << LEVELS;
  localparam int OW = IN_WIDTH + LEVELS;
  localparam bit SX = (SIGNED != 0);

  // Bit offset of level l inside the flat register vector; level l holds N>>l words of IN_WIDTH+l bits.
  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int j = 1; j < l; j++) o += (N >> j) * (IN_WIDTH + j);
    return o;
  endfunction

  localparam int TOT = lvl_off(LEVELS + 1);

  logic [TOT-1:0]    tree_q;
  logic [LEVELS-1:0] valid_q;
  logic [LEVELS-1:0] last_q;

  for (genvar gi = 1; gi <= LEVELS; gi++) begin : g_lvl
    localparam int W   = IN_WIDTH + gi;
    localparam int OFF = lvl_off(gi);
    for (genvar gj = 0; gj < (N >> gi); gj++) begin : g_node
      logic [W-2:0] a_w;
      logic [W-2:0] b_w;
      logic [W-1:0] sum_d;
      if (gi == 1) begin : g_src_in
        assign a_w = bus.inputs[2*gj];
        assign b_w = bus.inputs[2*gj+1];
      end else begin : g_src_lvl
        localparam int POFF = lvl_off(gi - 1);
        assign a_w = tree_q[POFF + (2*gj)*(W-1) +: W-1];
        assign b_w = tree_q[POFF + (2*gj+1)*(W-1) +: W-1];
      end
      assign sum_d = {SX & a_w[W-2], a_w} + {SX & b_w[W-2], b_w};
      always_ff @(posedge clk) begin
        if (rst) tree_q[OFF + gj*W +: W] <= '0;
        else     tree_q[OFF + gj*W +: W] <= sum_d;
      end
    end
  end

  logic [OW-1:0]        fin_sum;
  logic                 fin_valid;
  logic                 fin_last;
  logic [ACC_WIDTH-1:0] ext_w;

  assign fin_sum   = tree_q[TOT-1 -: OW];
  assign fin_valid = valid_q[LEVELS-1];
  assign fin_last  = last_q[LEVELS-1];

  if (ACC_WIDTH > OW) begin : g_ext
    assign ext_w = {{(ACC_WIDTH-OW){SX & fin_sum[OW-1]}}, fin_sum};
  end else begin : g_noext
    assign ext_w = fin_sum;
  end

  logic [ACC_WIDTH-1:0] acc_q, acc_d, base_w, acc_rep_q;
  logic                 ovf_q, ovf_d, carry_w, wrap_w;
  logic                 sof_q, acc_valid_q, acc_ovf_q;

  // A zero base at start-of-frame loads the new total and can never wrap.
  always_comb begin
    base_w           = sof_q ? '0 : acc_q;
    {carry_w, acc_d} = {1'b0, base_w} + {1'b0, ext_w};
    wrap_w           = SX ? ((base_w[ACC_WIDTH-1] == ext_w[ACC_WIDTH-1]) &&
                             (acc_d[ACC_WIDTH-1] != base_w[ACC_WIDTH-1]))
                          : carry_w;
    ovf_d            = (~sof_q & ovf_q) | wrap_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      sof_q       <= 1'b1;
      acc_valid_q <= 1'b0;
      acc_rep_q   <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      valid_q     <= LEVELS'({valid_q, bus.in_valid});
      last_q      <= LEVELS'({last_q, bus.in_valid & bus.in_last});
      acc_valid_q <= fin_valid & fin_last;
      if (fin_valid) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
        sof_q <= fin_last;
        if (fin_last) begin
          acc_rep_q <= acc_d;
          acc_ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.out_valid = fin_valid;
  assign bus.out       = fin_sum;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc       = acc_rep_q;
  assign bus.acc_ovf   = acc_ovf_q;
endmodule

// File: doc/atree_pipe.md
# atree_pipe

Pipelined, parametrised successor to the combinational adder tree. It reduces 2^LEVELS input words to one sum through one register stage per tree level, and carries a valid bit alongside the data. Inputs are zero- or sign-extended according to a mode parameter. A frame accumulator sums successive tree outputs until a `last`-tagged beat, then reports the frame total. It sits between the per-channel MAC/data sources and the result write-back logic.

## Interface
Parameters:
- `IN_WIDTH`, 8, width of each input word
- `LEVELS`, 4, tree depth; input count N = 2^LEVELS; LEVELS ≥ 1
- `SIGNED`, 0, 0 = inputs unsigned (zero-extend), 1 = two's complement (sign-extend)
- `ACC_WIDTH`, IN_WIDTH+LEVELS+8, frame accumulator width; must be ≥ IN_WIDTH+LEVELS

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `inputs` beat valid this cycle
- `in_last`  in  1  beat closes the current accumulation frame; qualified by `in_valid`
- `inputs`  in  [2^LEVELS-1:0][IN_WIDTH-1:0]  packed operand array
- `out_valid`  out  1  `out` holds a valid tree sum
- `out`  out  IN_WIDTH+LEVELS  tree sum of one beat
- `acc_valid`  out  1  one-cycle pulse; `acc` holds a completed frame total
- `acc`  out  ACC_WIDTH  frame total
- `acc_ovf`  out  1  the frame reported with this `acc_valid` overflowed ACC_WIDTH

## Operation
- Level l (1..LEVELS) adds pairs from level l-1. Each sum is IN_WIDTH+l bits wide and is registered.
- Operands are extended by one bit before each add: sign-extended if SIGNED=1, zero-extended otherwise. No level can overflow.
- `out` is the level-LEVELS register. `out` equals the exact sum of all N inputs as an (IN_WIDTH+LEVELS)-bit value.
- The valid/last sideband is a shift register of LEVELS stages, parallel to the data.
- Data registers capture every cycle. Data contents are don't-care when the corresponding valid bit is 0.
- No backpressure exists. A new beat can be accepted every cycle.
- Accumulator update on each cycle where the final stage is valid:
  - Start-of-frame (first beat after reset or after a `last` beat): `acc_r` = ext(out).
  - Otherwise: `acc_r` = `acc_r` + ext(out).
  - ext() is sign- or zero-extension to ACC_WIDTH per SIGNED.
- Overflow flag:
  - Set when an add wraps: unsigned carry-out, or signed overflow.
  - Cleared at start-of-frame.
  - Sticky within a frame.
- The accumulator wraps modulo 2^ACC_WIDTH.
- When the final stage carries `last`, the next cycle drives:
  - `acc_valid` = 1,
  - `acc` = the completed total,
  - `acc_ovf` = the frame's overflow flag.
- The next valid beat starts a new frame. Back-to-back frames need no idle cycles, including single-beat frames with `last` on every beat.
- `acc` holds its last reported value while `acc_valid` = 0.
- Reset clears all valid/last stages, the accumulator and start-of-frame state. In-flight beats and any partial frame are discarded without a report.

## Timing
- Reset values: `out_valid` 0, `out` 0, `acc_valid` 0, `acc` 0, `acc_ovf` 0. All pipeline data registers are 0.
- Tree latency: a beat sampled at edge k appears with `out_valid` = 1 after edge k+LEVELS.
- Frame latency: a `last` beat sampled at edge k gives `acc_valid` = 1 after edge k+LEVELS+1, for exactly one cycle.
- Throughput: 1 beat/cycle. `out_valid` mirrors `in_valid` delayed by LEVELS cycles, gaps included.
- `in_last` with `in_valid` = 0 is ignored.
- `rst` asserted on edge k: all outputs read reset values after edge k. Inputs sampled at edge k are dropped.
- The first accepted beat is at edge k+1 or later.

## Test plan
- Latency and flush (IN_WIDTH=8, LEVELS=2, SIGNED=0): single beat `inputs`={65,42,37,9}, `in_valid` for 1 cycle → `out`=153 with `out_valid` high exactly 2 cycles later, for 1 cycle. All zeros → 0. All 0xFF → 0x3FC.
- Signed mode (LEVELS=2, SIGNED=1): {127,-1,-128,5} → `out`=0x003. The same bits with SIGNED=0 → 0x203.
- Frame accumulate (LEVELS=2): three consecutive beats of {65,42,37,9}, `in_last` on the third → `acc`=459, `acc_valid` for 1 cycle, 3 cycles after the third beat. A 1-beat `last` frame immediately after → `acc`=153 on the next cycle, not 612.
- Streaming (LEVELS=4): 16 random beats back-to-back with random gaps → every `out` matches the reference sum in order, with `out_valid` delayed by 4 cycles.
- Overflow (IN_WIDTH=8, LEVELS=2, ACC_WIDTH=12): 16 beats of all 0xFF, last on the 16th → `acc`=4032, `acc_ovf`=1. The next frame of 1 beat → `acc_ovf`=0.
- Mid-frame reset: 2 beats of {1,1,1,1}, then `rst` for 1 cycle, then 1 beat of {1,1,1,1} with last → `acc`=4. No `acc_valid` for the pre-reset beats; `out_valid`=0 in the cycles after reset.
